// File: rtl/fpmul_pkg.sv
// Shared definitions for the floating-point multiplier dispatcher:
// FSM state encoding, flag vector layout and the canonical quiet NaN.
package fpmul_pkg;

    localparam int unsigned OPND_W = 64;   // one FIFO entry: {a, b}
    localparam int unsigned FLAG_W = 6;

    // Flag bit positions, MSB first: {OF, UF, NanF, InfF, DNF, ZF}
    localparam int unsigned FLAG_OF   = 5;
    localparam int unsigned FLAG_UF   = 4;
    localparam int unsigned FLAG_NANF = 3;
    localparam int unsigned FLAG_INFF = 2;
    localparam int unsigned FLAG_DNF  = 1;
    localparam int unsigned FLAG_ZF   = 0;

    localparam logic [FLAG_W-1:0] FLAGS_NAN_ONLY = FLAG_W'(1) << FLAG_NANF;
    localparam logic [31:0]       QNAN           = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP
    } state_t;

endpackage

// File: rtl/fpmul_opnd_fifo.sv
// Operand FIFO for the multiplier dispatcher. Entries are {a, b}.
// Pointers carry one extra MSB so full and empty are distinguished by the
// wrap bit alone; the head entry is presented combinationally.
module fpmul_opnd_fifo
    import fpmul_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [OPND_W-1:0] push_data,
    input  logic              pop,
    output logic [OPND_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [OPND_W-1:0] mem [DEPTH];

    // Pointer advance on push/pop; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since the pointers gate access.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fpmul_dispatch.sv
// Dispatcher in front of a single-precision multiplier: queues operand
// pairs, issues one operation at a time, and holds each result until the
// consumer takes it. Optional WAIT watchdog: define FPMUL_DISPATCH_TIMEOUT_EN.
module fpmul_dispatch
    import fpmul_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    output logic              mul_start,
    output logic [31:0]       mul_a,
    output logic [31:0]       mul_b,
    input  logic              mul_done,
    input  logic [31:0]       mul_p,
    input  logic [FLAG_W-1:0] mul_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_p,
    output logic [FLAG_W-1:0] out_flags,
    output logic              out_err,
    output logic              busy
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fpmul_dispatch: DEPTH must be a power of two, at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fpmul_dispatch: TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state;
    state_t            state_nxt;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OPND_W-1:0] fifo_head;
    logic              capture;
    logic              timeout;

    // in_ready looks only at registered occupancy: no same-cycle pop credit.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign capture   = (state == WAIT) && mul_done;
    assign busy      = !fifo_empty || (state != IDLE) || out_valid;

    fpmul_opnd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({in_a, in_b}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, start pulse and FIFO pop. The head is popped on the edge
    // entering ISSUE so the operands are already on mul_a/mul_b while
    // mul_start is high.
    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !out_valid) begin
                    state_nxt = ISSUE;
                    fifo_pop  = 1'b1;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mul_done || timeout) state_nxt = GAP;
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand register: only reloaded on the next pop, so it stays stable
    // from ISSUE through the GAP cycle following mul_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (fifo_pop) begin
            {mul_a, mul_b} <= fifo_head;
        end
    end

    // Result register: load on completion or watchdog abort, hold until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_flags <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_p     <= mul_p;
            out_flags <= mul_flags;
        end else if (timeout) begin
            out_valid <= 1'b1;
            out_p     <= QNAN;
            out_flags <= FLAGS_NAN_ONLY;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FPMUL_DISPATCH_TIMEOUT_EN
    localparam int unsigned       WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]   WD_ONE = WD_W'(1);
    localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd;

    // Fires on the TIMEOUT_CYCLES-th consecutive WAIT cycle without mul_done.
    assign timeout = (state == WAIT) && !mul_done && (wd == WD_MAX);

    // Watchdog counts WAIT cycles and clears everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           wd <= '0;
        else if (state == WAIT && !mul_done) wd <= wd + WD_ONE;
        else                               wd <= '0;
    end

    // Error flag tracks whether the held result came from an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          out_err <= 1'b0;
        else if (capture) out_err <= 1'b0;
        else if (timeout) out_err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpmul_dispatch.sv
// Self-checking bench for fpmul_dispatch with a behavioural multiplier and
// a result scoreboard. Define FPMUL_DISPATCH_TIMEOUT_EN to cover the watchdog.
`timescale 1ns/1ps
module tb_fpmul_dispatch;
    import fpmul_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done = 1'b0;
    logic [31:0] mul_p = '0;
    logic [5:0]  mul_flags = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_p;
    logic [5:0]  out_flags;
    logic        out_err;
    logic        busy;

    fpmul_dispatch #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_p     (mul_p),
        .mul_flags (mul_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_flags (out_flags),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [63:0] op_q[$];
    logic [38:0] sb[$];
    logic [38:0] sb_e;
    int          start_cyc[$];
    int          done_cyc[$];

    int          m_lat = 3;
    bit          m_en = 1'b1;
    int          m_cnt = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    int          spur_req = 0;
    int          spur_ack = 0;
    int          starts = 0;
    bit          exp_timeout = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (cyc > 20000) begin
            $display("FAIL global_timeout: cycle %0d, limit 20000", cyc);
            $fatal(1, "bench cycle budget exhausted");
        end
    end

    // Ideal multiplier results for the directed IEEE cases; any other pair
    // gets a distinctive scramble so ordering and routing errors show up.
    function automatic logic [37:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40000000_40400000: return {6'b000000, 32'h40C00000};
            64'h7F800000_3F800000: return {6'b000100, 32'h7F800000};
            64'h7FC00000_3F800000: return {6'b001000, 32'h7FC00000};
            default:               return {a[5:0] ^ b[11:6], a ^ {b[15:0], b[31:16]}};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        while (!in_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) chk("push_ready_wait", {63'b0, in_ready}, 64'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        op_q.push_back({a, b});
        if (exp_timeout) sb.push_back({1'b1, FLAGS_NAN_ONLY, QNAN});
        else             sb.push_back({1'b0, ref_mul(a, b)});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(tag, {63'b0, busy}, 64'd0);
    endtask

    task automatic wait_ov(input string tag);
        int t = 0;
        while (!out_valid && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(tag, {63'b0, out_valid}, 64'd1);
    endtask

    // Multiplier model: samples mul_start and drives mul_done m_lat cycles later.
    always @(negedge clk) begin
        if (rst) begin
            m_cnt    = 0;
            mul_done = 1'b0;
            spur_ack = spur_req;
        end else begin
            mul_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    chk("mul_operands_hold", {mul_a, mul_b}, {m_a, m_b});
                    {mul_flags, mul_p} = ref_mul(m_a, m_b);
                    mul_done = 1'b1;
                    done_cyc.push_back(cyc);
                end
            end
            if (spur_req != spur_ack) begin
                spur_ack  = spur_req;
                mul_p     = 32'h1234_5678;
                mul_flags = 6'b111111;
                mul_done  = 1'b1;
            end
            if (mul_start) begin
                starts++;
                start_cyc.push_back(cyc);
                m_a = mul_a;
                m_b = mul_b;
                if (op_q.size() == 0) chk("mul_start_expected", 64'd0, 64'd1);
                else                  chk("mul_operands", {mul_a, mul_b}, op_q.pop_front());
                if (m_en) m_cnt = m_lat;
            end
        end
    end

    // Scoreboard: each accepted result is checked against the next expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("result_expected", {63'b0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                sb_e = sb.pop_front();
                chk("result", {25'b0, out_err, out_flags, out_p}, {25'b0, sb_e});
            end
        end
    end

    int s0;
    int ns;
    int nd;
    int t_ov;

    initial begin
        // Reset values
        cycles(3);
        chk("rst_ctrl", {59'b0, mul_start, out_valid, out_err, busy, in_ready}, 64'd1);
        chk("rst_mul_ops", {mul_a, mul_b}, 64'd0);
        chk("rst_out", {26'b0, out_flags, out_p}, 64'd0);
        rst = 1'b0;

        // 2.0 * 3.0: start one cycle after the push edge
        s0 = starts;
        push(32'h40000000, 32'h40400000);
        chk("lat_no_start", {63'b0, mul_start}, 64'd0);
        cycles(1);
        chk("lat_start", {63'b0, mul_start}, 64'd1);
        wait_idle("idle_2x3");
        chk("one_start", 64'(starts - s0), 64'd1);

        // inf * 1 held under back-pressure, then NaN * 1
        out_ready = 1'b0;
        push(32'h7F800000, 32'h3F800000);
        wait_ov("ov_inf");
        repeat (4) begin
            cycles(1);
            chk("hold_valid", {63'b0, out_valid}, 64'd1);
            chk("hold_p", {32'b0, out_p}, 64'h7F800000);
            chk("hold_inff", {63'b0, out_flags[FLAG_INFF]}, 64'd1);
        end
        out_ready = 1'b1;
        wait_idle("idle_inf");
        push(32'h7FC00000, 32'h3F800000);
        wait_ov("ov_nan");
        chk("nanf", {63'b0, out_flags[FLAG_NANF]}, 64'd1);
        wait_idle("idle_nan");

        // Five pairs with the consumer stalled
        out_ready = 1'b0;
        m_lat     = 2;
        s0        = starts;
        for (int i = 0; i < 5; i++) push($urandom, $urandom);
        cycles(12);
        chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        chk("bp_held", {63'b0, out_valid}, 64'd1);
        chk("bp_one_start", 64'(starts - s0), 64'd1);
        out_ready = 1'b1;
        wait_idle("idle_bp");
        chk("bp_five_starts", 64'(starts - s0), 64'd5);

        // Back-to-back ops with single-cycle multiplier
        m_lat = 1;
        ns    = start_cyc.size();
        nd    = done_cyc.size();
        push($urandom, $urandom);
        push($urandom, $urandom);
        wait_idle("idle_fast");
        chk("fast_counts", {62'b0, start_cyc.size() > ns + 1, done_cyc.size() > nd}, 64'd3);
        if (start_cyc.size() > ns + 1 && done_cyc.size() > nd) begin
            chk("done_one_after_start", 64'(done_cyc[nd] - start_cyc[ns]), 64'd1);
            chk("gap_after_done", {63'b0, (start_cyc[ns + 1] - done_cyc[nd]) >= 2}, 64'd1);
        end

        // Spurious mul_done while idle
        out_ready = 1'b0;
        spur_req++;
        cycles(4);
        chk("spurious_ignored", {62'b0, busy, out_valid}, 64'd0);
        out_ready = 1'b1;

        // Reset during WAIT with three entries queued
        m_lat = 50;
        for (int i = 0; i < 4; i++) push($urandom, $urandom);
        cycles(3);
        rst = 1'b1;
        op_q.delete();
        sb.delete();
        cycles(1);
        chk("rst_mid_ctrl", {59'b0, mul_start, out_valid, out_err, busy, in_ready}, 64'd1);
        chk("rst_mid_ops", {mul_a, mul_b}, 64'd0);
        chk("rst_mid_out", {26'b0, out_flags, out_p}, 64'd0);
        rst   = 1'b0;
        m_lat = 3;
        push(32'h40000000, 32'h40400000);
        wait_idle("idle_after_rst");

`ifdef FPMUL_DISPATCH_TIMEOUT_EN
        // Watchdog abort: multiplier never answers
        m_en        = 1'b0;
        exp_timeout = 1'b1;
        ns          = start_cyc.size();
        out_ready   = 1'b0;
        push(32'h3F800000, 32'h3F800000);
        exp_timeout = 1'b0;
        wait_ov("ov_timeout");
        t_ov = cyc;
        chk("to_err", {63'b0, out_err}, 64'd1);
        chk("to_p", {32'b0, out_p}, {32'b0, QNAN});
        chk("to_flags", {58'b0, out_flags}, {58'b0, FLAGS_NAN_ONLY});
        chk("to_started", {63'b0, start_cyc.size() > ns}, 64'd1);
        if (start_cyc.size() > ns) chk("to_latency", 64'(t_ov - start_cyc[ns]), 64'd65);
        out_ready = 1'b1;
        wait_idle("idle_timeout");
        m_en = 1'b1;
        push(32'h40000000, 32'h40400000);
        wait_idle("idle_after_timeout");
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
